chad_coproc: RTL and testbench
==============================

# chad_coproc

Multi-cycle arithmetic coprocessor for the chad core, attached to its `copgo`/`copa`/`copb`/`copc`/`cop` port group. It generalises the single-cycle ALU with operand-width-parametrised iterative unsigned multiply, unsigned divide and barrel-free shifts. It also adds a stall handshake (`busy`), which the core ORs into its `hold`.

## Interface
- `WIDTH`, 18, cell size; legal 16..32, matches core `WIDTH`

- `clk`  in  1  clock; all state on rising edge
- `resetq`  in  1  reset, synchronous, active-low
- `copgo`  in  1  start request from core (`insn[15:11]==5'b11101`)
- `sel`  in  11  operation select, = core `insn[10:0]`
- `hold_ext`  in  1  OR of all other core hold sources
- `copa`  in  WIDTH  T (count / divisor)
- `copb`  in  WIDTH  N (multiplicand / dividend low / shift data)
- `copc`  in  WIDTH  W (dividend high)
- `busy`  out  1  stall request to core hold; combinational
- `cop`  out  WIDTH  result register

## Operation
- Ops are decoded only when `sel[10:3]==0`. Any other `sel` is ignored: no start, no state change, `busy` low.
- `sel[2:0]` selects the op:
  - 0 UMUL: {hi,cop} = copb*copa.
  - 1 UDIV: {copc,copb} / copa; quotient→cop, remainder→hi.
  - 2 LSL: cop = copb<<copa[5:0].
  - 3 LSR: logical right shift.
  - 4 ASR: arithmetic right shift.
  - 5 RDHI: cop=hi.
  - 6 RDST: cop={0…,ovf,dz}.
  - 7: same as 5.
- States are IDLE, RUN, DONE.
- `start = copgo & (state==IDLE) & resetq & valid sel`.
- `busy = start | (state==RUN)`.
- IDLE + start:
  - Ops 5–7: result is written, then go to DONE.
  - Ops 0–4: operands are latched, the iteration counter is loaded, then go to RUN.
  - A shift with count 0 goes directly to DONE with cop=copb.
- RUN:
  - UMUL: one shift-add step per cycle, WIDTH steps.
  - UDIV: one restoring step per cycle, WIDTH steps.
  - Shifts: one bit per cycle for min(count,WIDTH) steps. Count ≥ WIDTH gives 0 for LSL/LSR and all sign bits for ASR.
  - Last step → DONE.
- DONE:
  - `busy` is low, so the core retires the copgo instruction in this cycle.
  - `copgo` is ignored in DONE.
  - Stay in DONE while `hold_ext`=1 (same insn is still presented). Otherwise go to IDLE.
- UDIV boundaries:
  - copa==0: cop=all ones, hi=copb, dz=1.
  - copc≥copa (quotient overflow): cop=all ones, hi=copb, ovf=1.
  - Both cases take 1 cycle (IDLE→DONE).
  - Any successful UDIV clears dz and ovf.
  - Other ops leave the flags unchanged.
- Arithmetic is unsigned modulo 2^WIDTH except ASR. hi is WIDTH bits.
- `cop` changes only on op completion (RUN last step, or IDLE start for 1-cycle ops). It holds its value otherwise, including during RUN.

## Timing
- Reset (resetq low at an edge): state=IDLE, cop=0, hi=0, dz=ovf=0, counter=0.
  - `busy`=0 combinationally while resetq is low.
  - Reset during RUN aborts the operation; no partial result is kept.
- Start is the cycle the core presents copgo in IDLE; `busy` is high that same cycle.
- Latency (`busy` high cycles):
  - UMUL/UDIV: 1+WIDTH.
  - Shift by n: 1+min(n,WIDTH); n=0 → 1.
  - Ops 5–7 and UDIV fault: 1.
- `cop` is valid from the DONE cycle onward and stays stable until the next completion.
- Back-to-back copgo instructions: the second is seen after DONE→IDLE. The minimum spacing is naturally met because the core advances exactly once in DONE.
- `hold_ext` asserted in RUN has no effect on the iteration. In DONE it extends DONE.

## Configuration
- `CHAD_COP_DIVIDE_EN` defined: UDIV is implemented as above.
- Not defined:
  - No divider datapath.
  - sel 1 completes in 1 cycle with cop=all ones, hi unchanged, ovf=1, dz=0.
  - All other ops are identical.

## Test plan
- WIDTH=18, UMUL copb=copa=0x3FFFF → `busy` high 19 cycles; cop=0x00001; then RDHI → cop=0x3FFFE in 1 cycle.
- UDIV copc=0, copb=100, copa=7 → cop=14, RDHI=2, RDST=0. UDIV copa=0, copb=5 → cop=0x3FFFF, hi=5, RDST=0x1, `busy` 1 cycle. Without the macro: cop=0x3FFFF, RDST=0x2.
- ASR copb=0x20000, copa=3 → `busy` 4 cycles, cop=0x3C000. LSL count 0 → `busy` 1 cycle, cop=copb. LSR count 40 → cop=0.
- copgo held (same insn) with `hold_ext`=1 for 3 cycles after DONE → exactly one operation executes, no restart, `busy` stays low.
- resetq low at RUN cycle 5 of UMUL → next cycle state IDLE, `busy`=0, cop=0. A following UMUL 3×5 gives cop=15.
- sel=0x008 with copgo → `busy` never rises; cop and flags unchanged.

Source files
------------

// File: rtl/chad_coproc.sv
// Multi-cycle arithmetic coprocessor for the chad core: iterative UMUL, UDIV and shifts.
// Define CHAD_COP_DIVIDE_EN to build the restoring divider; otherwise UDIV reports overflow.
module chad_coproc #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             copgo,
    input  logic [10:0]      sel,
    input  logic             hold_ext,
    input  logic [WIDTH-1:0] copa,
    input  logic [WIDTH-1:0] copb,
    input  logic [WIDTH-1:0] copc,
    output logic             busy,
    output logic [WIDTH-1:0] cop
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cop_q, cop_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;

    logic             validSel;
    logic             start;
    logic [5:0]       shiftSteps;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] stepHi, stepLo;

    assign validSel   = (sel[10:3] == 8'd0);
    assign start      = copgo & (state_q == IDLE) & resetq & validSel;
    assign busy       = resetq & (start | (state_q == RUN));
    assign cop        = cop_q;
    assign shiftSteps = (copa[5:0] >= 6'(WIDTH)) ? 6'(WIDTH) : copa[5:0];
    assign mulSum     = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);

`ifdef CHAD_COP_DIVIDE_EN
    // Restoring step: the remainder stays below the divisor, so WIDTH+1 bits suffice.
    logic [WIDTH:0]   divTrial;
    logic [WIDTH:0]   divDiff;
    logic             divFits;
    assign divTrial = {accHi_q, accLo_q[WIDTH-1]};
    assign divDiff  = divTrial - {1'b0, opnd_q};
    assign divFits  = (divTrial >= {1'b0, opnd_q});
`else
    logic unused_copc;
    assign unused_copc = ^copc;
`endif

    always_comb begin
        stepHi = accHi_q;
        stepLo = accLo_q;
        case (op_q)
            3'd0: begin
                stepHi = mulSum[WIDTH:1];
                stepLo = {mulSum[0], accLo_q[WIDTH-1:1]};
            end
`ifdef CHAD_COP_DIVIDE_EN
            3'd1: begin
                stepHi = divFits ? divDiff[WIDTH-1:0] : divTrial[WIDTH-1:0];
                stepLo = {accLo_q[WIDTH-2:0], divFits};
            end
`endif
            3'd2:    stepLo = {accLo_q[WIDTH-2:0], 1'b0};
            3'd3:    stepLo = {1'b0, accLo_q[WIDTH-1:1]};
            3'd4:    stepLo = {accLo_q[WIDTH-1], accLo_q[WIDTH-1:1]};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cop_d   = cop_q;
        hi_d    = hi_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        accHi_d = accHi_q;
        accLo_d = accLo_q;
        opnd_d  = opnd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = sel[2:0];
                    case (sel[2:0])
                        3'd0: begin
                            accHi_d = '0;
                            accLo_d = copa;
                            opnd_d  = copb;
                            cnt_d   = 6'(WIDTH);
                            state_d = RUN;
                        end
                        3'd1: begin
`ifdef CHAD_COP_DIVIDE_EN
                            if (copa == '0) begin
                                cop_d   = '1;
                                hi_d    = copb;
                                dz_d    = 1'b1;
                                ovf_d   = 1'b0;
                                state_d = DONE;
                            end else if (copc >= copa) begin
                                cop_d   = '1;
                                hi_d    = copb;
                                dz_d    = 1'b0;
                                ovf_d   = 1'b1;
                                state_d = DONE;
                            end else begin
                                accHi_d = copc;
                                accLo_d = copb;
                                opnd_d  = copa;
                                cnt_d   = 6'(WIDTH);
                                state_d = RUN;
                            end
`else
                            cop_d   = '1;
                            dz_d    = 1'b0;
                            ovf_d   = 1'b1;
                            state_d = DONE;
`endif
                        end
                        3'd2, 3'd3, 3'd4: begin
                            if (shiftSteps == 6'd0) begin
                                cop_d   = copb;
                                state_d = DONE;
                            end else begin
                                accLo_d = copb;
                                cnt_d   = shiftSteps;
                                state_d = RUN;
                            end
                        end
                        3'd6: begin
                            cop_d   = WIDTH'({ovf_q, dz_q});
                            state_d = DONE;
                        end
                        default: begin
                            cop_d   = hi_q;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            RUN: begin
                accHi_d = stepHi;
                accLo_d = stepLo;
                cnt_d   = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    cop_d   = stepLo;
                    state_d = DONE;
                    if (op_q == 3'd0) begin
                        hi_d = stepHi;
                    end
                    if (op_q == 3'd1) begin
                        hi_d  = stepHi;
                        dz_d  = 1'b0;
                        ovf_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (!hold_ext) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q <= IDLE;
            cop_q   <= '0;
            hi_q    <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            accHi_q <= '0;
            accLo_q <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            cop_q   <= cop_d;
            hi_q    <= hi_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
            opnd_q  <= opnd_d;
        end
    end

endmodule

// File: tb/tb_chad_coproc.sv
// Directed self-checking bench for chad_coproc at WIDTH=18; expectations follow CHAD_COP_DIVIDE_EN.
module tb_chad_coproc;

    localparam int W = 18;

    logic         clk;
    logic         resetq;
    logic         copgo;
    logic [10:0]  sel;
    logic         hold_ext;
    logic [W-1:0] copa;
    logic [W-1:0] copb;
    logic [W-1:0] copc;
    logic         busy;
    logic [W-1:0] cop;

    int checkCount = 0;
    int failCount  = 0;

    chad_coproc #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetq   (resetq),
        .copgo    (copgo),
        .sel      (sel),
        .hold_ext (hold_ext),
        .copa     (copa),
        .copb     (copb),
        .copc     (copc),
        .busy     (busy),
        .cop      (cop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one copgo instruction like the core would, count busy cycles, then
    // optionally keep it presented with hold_ext high for a few DONE cycles.
    task automatic applyStimulus(input string tag, input logic [10:0] s,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c, input int holdCycles,
                                 input int expCycles, input logic [W-1:0] expCop);
        int cycles;
        @(negedge clk);
        sel      = s;
        copa     = a;
        copb     = b;
        copc     = c;
        copgo    = 1'b1;
        hold_ext = 1'b0;
        #1;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        if (cycles >= 100) checkOutput({tag, ".timeout"}, 32'(cycles), 32'd0);
        checkOutput({tag, ".cycles"}, 32'(cycles), 32'(expCycles));
        checkOutput({tag, ".cop"}, 32'(cop), 32'(expCop));
        for (int i = 0; i < holdCycles; i++) begin
            hold_ext = 1'b1;
            @(negedge clk);
            #1;
            checkOutput({tag, ".holdBusy"}, 32'(busy), 32'd0);
            checkOutput({tag, ".holdCop"}, 32'(cop), 32'(expCop));
        end
        copgo    = 1'b0;
        hold_ext = 1'b0;
    endtask

    initial begin
        resetq   = 1'b0;
        copgo    = 1'b0;
        sel      = '0;
        hold_ext = 1'b0;
        copa     = '0;
        copb     = '0;
        copc     = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.cop", 32'(cop), 32'd0);
        resetq = 1'b1;

        applyStimulus("rdstReset", 11'd6, 18'd0, 18'd0, 18'd0, 0, 1, 18'h00000);
        applyStimulus("umulMax", 11'd0, 18'h3FFFF, 18'h3FFFF, 18'd0, 0, 19, 18'h00001);
        applyStimulus("rdhiMax", 11'd5, 18'd0, 18'd0, 18'd0, 0, 1, 18'h3FFFE);
        applyStimulus("umulSmall", 11'd0, 18'h00045, 18'h00123, 18'd0, 0, 19, 18'h04E6F);
        applyStimulus("rdhiOp7", 11'd7, 18'd0, 18'd0, 18'd0, 0, 1, 18'h00000);

`ifdef CHAD_COP_DIVIDE_EN
        applyStimulus("udiv", 11'd1, 18'd7, 18'd100, 18'd0, 0, 19, 18'd14);
        applyStimulus("udivRdhi", 11'd5, 18'd0, 18'd0, 18'd0, 0, 1, 18'd2);
        applyStimulus("udivRdst", 11'd6, 18'd0, 18'd0, 18'd0, 0, 1, 18'd0);
        applyStimulus("udivZero", 11'd1, 18'd0, 18'd5, 18'd0, 0, 1, 18'h3FFFF);
        applyStimulus("udivZeroRdhi", 11'd5, 18'd0, 18'd0, 18'd0, 0, 1, 18'd5);
        applyStimulus("udivZeroRdst", 11'd6, 18'd0, 18'd0, 18'd0, 0, 1, 18'h1);
        applyStimulus("udivOvf", 11'd1, 18'd7, 18'd9, 18'd7, 0, 1, 18'h3FFFF);
        applyStimulus("udivOvfRdhi", 11'd5, 18'd0, 18'd0, 18'd0, 0, 1, 18'd9);
        applyStimulus("udivOvfRdst", 11'd6, 18'd0, 18'd0, 18'd0, 0, 1, 18'h2);
`else
        applyStimulus("udiv", 11'd1, 18'd7, 18'd100, 18'd0, 0, 1, 18'h3FFFF);
        applyStimulus("udivRdhi", 11'd5, 18'd0, 18'd0, 18'd0, 0, 1, 18'd0);
        applyStimulus("udivRdst", 11'd6, 18'd0, 18'd0, 18'd0, 0, 1, 18'h2);
        applyStimulus("udivZero", 11'd1, 18'd0, 18'd5, 18'd0, 0, 1, 18'h3FFFF);
        applyStimulus("udivZeroRdhi", 11'd5, 18'd0, 18'd0, 18'd0, 0, 1, 18'd0);
        applyStimulus("udivZeroRdst", 11'd6, 18'd0, 18'd0, 18'd0, 0, 1, 18'h2);
`endif

        applyStimulus("asr3", 11'd4, 18'd3, 18'h20000, 18'd0, 0, 4, 18'h3C000);
        applyStimulus("lsl0", 11'd2, 18'd0, 18'h01234, 18'd0, 0, 1, 18'h01234);
        applyStimulus("lsr40", 11'd3, 18'd40, 18'h3FFFF, 18'd0, 0, 19, 18'h00000);
        applyStimulus("lslHold", 11'd2, 18'd4, 18'h00005, 18'd0, 3, 5, 18'h00050);
        applyStimulus("asr40", 11'd4, 18'd40, 18'h20001, 18'd0, 0, 19, 18'h3FFFF);
        applyStimulus("badSel", 11'h008, 18'd3, 18'd5, 18'd0, 2, 0, 18'h3FFFF);
        applyStimulus("badSelRdst", 11'd6, 18'd0, 18'd0, 18'd0, 0, 1, 18'h2);

        // Abort a long multiply part-way through with a synchronous reset.
        @(negedge clk);
        sel   = 11'd0;
        copa  = 18'h3FFFF;
        copb  = 18'h3FFFF;
        copgo = 1'b1;
        #1;
        checkOutput("abort.startBusy", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("abort.runBusy", 32'(busy), 32'd1);
        resetq = 1'b0;
        copgo  = 1'b0;
        #1;
        checkOutput("abort.busyComb", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.cop", 32'(cop), 32'd0);
        resetq = 1'b1;
        applyStimulus("abortRdhi", 11'd5, 18'd0, 18'd0, 18'd0, 0, 1, 18'd0);
        applyStimulus("abortRdst", 11'd6, 18'd0, 18'd0, 18'd0, 0, 1, 18'd0);
        applyStimulus("umul3x5", 11'd0, 18'd3, 18'd5, 18'd0, 0, 19, 18'd15);
        applyStimulus("umul3x5Rdhi", 11'd5, 18'd0, 18'd0, 18'd0, 0, 1, 18'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
